// File: rtl/uart_shk_pkg.sv
// Shared constants, state encodings and baud-rate helpers for the UART-to-shake bridge.
package uart_shk_pkg;

    localparam int NB_FRAME_BITS = 11;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_OVRN   = 1;
    localparam int ERR_TOUT   = 2;
    localparam int ERR_FSTART = 3;

    typedef enum logic [1:0] {
        SHK_IDLE     = 2'd0,
        SHK_ADDR     = 2'd1,
        SHK_WAIT_RDY = 2'd2,
        SHK_SYNC     = 2'd3
    } shk_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    function automatic int calc_baud_numb(input int sys_fre, input int baud_rate);
        return sys_fre / baud_rate;
    endfunction

    function automatic int calc_baud_width(input int baud_numb);
        return $clog2(baud_numb + 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampler (MSB first), one-cycle byte strobe,
// framing and false-start pulses, plus a start-detect pulse for the inter-byte timer.
module uart_rx_byte
    import uart_shk_pkg::*;
#(
    parameter int NB_BAUD_NUMB = 868,
    parameter int WD_BAUD_NUMB = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       start_det,
    output logic       frame_err,
    output logic       false_start
);

    localparam logic [WD_BAUD_NUMB-1:0] BAUD_FULL = WD_BAUD_NUMB'(NB_BAUD_NUMB);
    localparam logic [WD_BAUD_NUMB-1:0] BAUD_HALF = WD_BAUD_NUMB'(NB_BAUD_NUMB / 2);
    localparam logic [WD_BAUD_NUMB-1:0] BAUD_ONE  = WD_BAUD_NUMB'(1);
    localparam logic [WD_BAUD_NUMB-1:0] BAUD_ZERO = WD_BAUD_NUMB'(0);
    // Frame minus start bit and two stop bits gives the data bit count; index of the last one.
    localparam logic [2:0] LAST_BIT = 3'(NB_FRAME_BITS - 4);

    logic                    sync1_r;
    logic                    sync2_r;
    rx_state_e               state_r;
    rx_state_e               state_nxt;
    logic [WD_BAUD_NUMB-1:0] cnt_r;
    logic [WD_BAUD_NUMB-1:0] cnt_nxt;
    logic [2:0]              bit_r;
    logic [2:0]              bit_nxt;
    logic [7:0]              shift_r;
    logic [7:0]              shift_nxt;
    logic                    vld_r;
    logic                    vld_nxt;
    logic                    sdet_r;
    logic                    sdet_nxt;
    logic                    ferr_r;
    logic                    ferr_nxt;
    logic                    fstart_r;
    logic                    fstart_nxt;

    // Line synchronizer, idling high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receiver state, bit timing and registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= RX_IDLE;
            cnt_r    <= BAUD_ZERO;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            vld_r    <= 1'b0;
            sdet_r   <= 1'b0;
            ferr_r   <= 1'b0;
            fstart_r <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            bit_r    <= bit_nxt;
            shift_r  <= shift_nxt;
            vld_r    <= vld_nxt;
            sdet_r   <= sdet_nxt;
            ferr_r   <= ferr_nxt;
            fstart_r <= fstart_nxt;
        end
    end

    // Next-state logic: cnt_r counts clocks since the last sample point.
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        bit_nxt    = bit_r;
        shift_nxt  = shift_r;
        vld_nxt    = 1'b0;
        sdet_nxt   = 1'b0;
        ferr_nxt   = 1'b0;
        fstart_nxt = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (!sync2_r) begin
                    state_nxt = RX_START;
                    cnt_nxt   = BAUD_ONE;
                    sdet_nxt  = 1'b1;
                end else begin
                    cnt_nxt = BAUD_ZERO;
                end
            end
            RX_START: begin
                if (cnt_r == BAUD_HALF) begin
                    if (sync2_r) begin
                        state_nxt  = RX_IDLE;
                        fstart_nxt = 1'b1;
                    end else begin
                        state_nxt = RX_DATA;
                        cnt_nxt   = BAUD_ONE;
                        bit_nxt   = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt_r + BAUD_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == BAUD_FULL) begin
                    shift_nxt = {shift_r[6:0], sync2_r};
                    cnt_nxt   = BAUD_ONE;
                    if (bit_r == LAST_BIT) begin
                        state_nxt = RX_STOP;
                        bit_nxt   = 3'd0;
                    end else begin
                        bit_nxt = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + BAUD_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == BAUD_FULL) begin
                    cnt_nxt = BAUD_ZERO;
                    if (sync2_r) begin
                        state_nxt = RX_IDLE;
                        vld_nxt   = 1'b1;
                    end else begin
                        state_nxt = RX_WAIT_HIGH;
                        ferr_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r + BAUD_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_r) begin
                    state_nxt = RX_IDLE;
                end else begin
                    state_nxt = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
                cnt_nxt   = BAUD_ZERO;
            end
        endcase
    end

    assign byte_vld    = vld_r;
    assign byte_data   = shift_r;
    assign start_det   = sdet_r;
    assign frame_err   = ferr_r;
    assign false_start = fstart_r;

endmodule

// File: rtl/uart_to_shk.sv
// UART-to-shake bridge: replays received (address, data) byte pairs as shake-bus writes.
// Optional inter-byte timeout is enabled with the UART_TO_SHK_TIMEOUT_EN macro.
module uart_to_shk
    import uart_shk_pkg::*;
#(
    parameter int NB_BAUD_RATE    = 115200,
    parameter int NB_SYS_FRE      = 100_000_000,
    parameter int WD_SHK_DATA     = 8,
    parameter int WD_SHK_ADDR     = 8,
    parameter int WD_ERR_INFO     = 4,
    parameter int NB_TIMEOUT_BITS = 32
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_reset,
    input  logic                   s_port_uart_rx,
    output logic                   m_shk_wr_valid,
    output logic                   m_shk_wr_msync,
    output logic [WD_SHK_DATA-1:0] m_shk_wr_mdata,
    output logic [WD_SHK_ADDR-1:0] m_shk_wr_maddr,
    input  logic                   m_shk_wr_ready,
    input  logic                   i_err_clr,
    output logic [WD_ERR_INFO-1:0] m_err_uart_info1
);

    localparam int NB_BAUD_NUMB = calc_baud_numb(NB_SYS_FRE, NB_BAUD_RATE);
    localparam int WD_BAUD_NUMB = calc_baud_width(NB_BAUD_NUMB);

    if (WD_SHK_DATA != 8 || WD_SHK_ADDR != 8 || WD_ERR_INFO < 4 || NB_TIMEOUT_BITS < 1) begin : g_param_check
        $error("uart_to_shk: unsupported parameter set");
    end

    logic                   rx_vld_s;
    logic [7:0]             rx_byte_s;
    logic                   rx_start_det_s;
    logic                   rx_ferr_s;
    logic                   rx_fstart_s;
    shk_state_e             state_r;
    shk_state_e             state_nxt;
    logic                   valid_r;
    logic                   valid_nxt;
    logic                   msync_r;
    logic                   msync_nxt;
    logic [WD_SHK_ADDR-1:0] maddr_r;
    logic [WD_SHK_ADDR-1:0] maddr_nxt;
    logic [WD_SHK_DATA-1:0] mdata_r;
    logic [WD_SHK_DATA-1:0] mdata_nxt;
    logic                   ovrn_s;
    logic                   tout_s;
    logic                   tout_hit_s;
    logic [WD_ERR_INFO-1:0] err_evt_s;
    logic [WD_ERR_INFO-1:0] err_r;

    uart_rx_byte #(
        .NB_BAUD_NUMB (NB_BAUD_NUMB),
        .WD_BAUD_NUMB (WD_BAUD_NUMB)
    ) u_rx (
        .clk         (i_sys_clk),
        .reset       (i_sys_reset),
        .rx          (s_port_uart_rx),
        .byte_vld    (rx_vld_s),
        .byte_data   (rx_byte_s),
        .start_det   (rx_start_det_s),
        .frame_err   (rx_ferr_s),
        .false_start (rx_fstart_s)
    );

`ifdef UART_TO_SHK_TIMEOUT_EN
    localparam int TOUT_LIMIT = NB_TIMEOUT_BITS * NB_BAUD_NUMB;
    localparam int WD_TOUT    = $clog2(TOUT_LIMIT + 1);
    localparam logic [WD_TOUT-1:0] TOUT_LAST = WD_TOUT'(TOUT_LIMIT - 1);

    logic [WD_TOUT-1:0] tout_cnt_r;

    // Inter-byte timer: runs only while awaiting the data byte, re-armed by every new start bit.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            tout_cnt_r <= {WD_TOUT{1'b0}};
        end else if (state_r != SHK_ADDR || rx_start_det_s) begin
            tout_cnt_r <= {WD_TOUT{1'b0}};
        end else begin
            tout_cnt_r <= tout_cnt_r + WD_TOUT'(1);
        end
    end

    assign tout_hit_s = (state_r == SHK_ADDR) && (tout_cnt_r == TOUT_LAST);
`else
    logic start_det_unused_s;
    assign start_det_unused_s = rx_start_det_s;
    assign tout_hit_s         = 1'b0;
`endif

    // Transaction state and registered bus outputs.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state_r <= SHK_IDLE;
            valid_r <= 1'b0;
            msync_r <= 1'b0;
            maddr_r <= {WD_SHK_ADDR{1'b0}};
            mdata_r <= {WD_SHK_DATA{1'b0}};
        end else begin
            state_r <= state_nxt;
            valid_r <= valid_nxt;
            msync_r <= msync_nxt;
            maddr_r <= maddr_nxt;
            mdata_r <= mdata_nxt;
        end
    end

    // Next-state logic; msync is computed one cycle ahead so it appears exactly in SYNC.
    always_comb begin
        state_nxt = state_r;
        valid_nxt = valid_r;
        msync_nxt = 1'b0;
        maddr_nxt = maddr_r;
        mdata_nxt = mdata_r;
        ovrn_s    = 1'b0;
        tout_s    = 1'b0;
        case (state_r)
            SHK_IDLE: begin
                if (rx_vld_s) begin
                    maddr_nxt = WD_SHK_ADDR'(rx_byte_s);
                    valid_nxt = 1'b1;
                    state_nxt = SHK_ADDR;
                end else begin
                    valid_nxt = 1'b0;
                end
            end
            SHK_ADDR: begin
                if (rx_vld_s) begin
                    mdata_nxt = WD_SHK_DATA'(rx_byte_s);
                    if (m_shk_wr_ready) begin
                        state_nxt = SHK_SYNC;
                        msync_nxt = 1'b1;
                    end else begin
                        state_nxt = SHK_WAIT_RDY;
                    end
                end else if (tout_hit_s) begin
                    state_nxt = SHK_IDLE;
                    valid_nxt = 1'b0;
                    tout_s    = 1'b1;
                end else begin
                    state_nxt = SHK_ADDR;
                end
            end
            SHK_WAIT_RDY: begin
                ovrn_s = rx_vld_s;
                if (m_shk_wr_ready) begin
                    state_nxt = SHK_SYNC;
                    msync_nxt = 1'b1;
                end else begin
                    state_nxt = SHK_WAIT_RDY;
                end
            end
            SHK_SYNC: begin
                ovrn_s    = rx_vld_s;
                state_nxt = SHK_IDLE;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = SHK_IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Gather this cycle's error events into their flag positions.
    always_comb begin
        err_evt_s             = {WD_ERR_INFO{1'b0}};
        err_evt_s[ERR_FRAME]  = rx_ferr_s;
        err_evt_s[ERR_OVRN]   = ovrn_s;
        err_evt_s[ERR_TOUT]   = tout_s;
        err_evt_s[ERR_FSTART] = rx_fstart_s;
    end

    // Sticky error flags; an event coinciding with a clear still leaves its bit set.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            err_r <= {WD_ERR_INFO{1'b0}};
        end else if (i_err_clr) begin
            err_r <= err_evt_s;
        end else begin
            err_r <= err_r | err_evt_s;
        end
    end

    assign m_shk_wr_valid   = valid_r;
    assign m_shk_wr_msync   = msync_r;
    assign m_shk_wr_maddr   = maddr_r;
    assign m_shk_wr_mdata   = mdata_r;
    assign m_err_uart_info1 = err_r;

endmodule

// File: tb/tb_uart_to_shk.sv
// Directed bench for uart_to_shk at 10 clocks per bit; timeout checks need UART_TO_SHK_TIMEOUT_EN.
module tb_uart_to_shk;

    localparam int CLK_P    = 10;
    localparam int BIT_CLKS = 10;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       ready   = 1'b1;
    logic       err_clr = 1'b0;
    logic       valid;
    logic       msync;
    logic [7:0] mdata;
    logic [7:0] maddr;
    logic [3:0] err;

    int n_cmp = 0;
    int n_bad = 0;

    int         open_cnt    = 0;
    int         sync_cnt    = 0;
    int         addr_chg    = 0;
    int         hi_len      = 0;
    int         last_hi_len = 0;
    time        open_t      = 0;
    time        sync_t      = 0;
    logic [7:0] open_addr   = 8'h00;
    logic [7:0] sync_addr   = 8'h00;
    logic [7:0] sync_data   = 8'h00;
    logic       sync_vld    = 1'b0;
    logic       valid_q     = 1'b0;
    logic [7:0] maddr_q     = 8'h00;

    uart_to_shk #(
        .NB_BAUD_RATE    (115200),
        .NB_SYS_FRE      (1_152_000),
        .WD_SHK_DATA     (8),
        .WD_SHK_ADDR     (8),
        .WD_ERR_INFO     (4),
        .NB_TIMEOUT_BITS (32)
    ) dut (
        .i_sys_clk        (clk),
        .i_sys_reset      (rst),
        .s_port_uart_rx   (rx),
        .m_shk_wr_valid   (valid),
        .m_shk_wr_msync   (msync),
        .m_shk_wr_mdata   (mdata),
        .m_shk_wr_maddr   (maddr),
        .m_shk_wr_ready   (ready),
        .i_err_clr        (err_clr),
        .m_err_uart_info1 (err)
    );

    always #(CLK_P / 2) clk = ~clk;

    // Bus observer: records transaction openings, strobes and address stability.
    always @(negedge clk) begin
        if (valid && !valid_q) begin
            open_cnt  = open_cnt + 1;
            open_t    = $time;
            open_addr = maddr;
            hi_len    = 0;
        end
        if (valid) hi_len = hi_len + 1;
        if (!valid && valid_q) last_hi_len = hi_len;
        if (valid && valid_q && (maddr != maddr_q)) addr_chg = addr_chg + 1;
        if (msync) begin
            sync_cnt  = sync_cnt + 1;
            sync_t    = $time;
            sync_addr = maddr;
            sync_data = mdata;
            sync_vld  = valid;
        end
        valid_q = valid;
        maddr_q = maddr;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output time t0);
        @(negedge clk);
        rx = 1'b0;
        t0 = $time;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        time t0;
        time t1;
        time t_rdy;
        int  o0;
        int  s0;
        int  c0;

        repeat (5) @(negedge clk);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_msync", 32'(msync), 32'd0);
        check_eq("rst_maddr", 32'(maddr), 32'd0);
        check_eq("rst_mdata", 32'(mdata), 32'd0);
        check_eq("rst_err",   32'(err),   32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of the data byte aborts the open write.
        send_byte(8'h11, 1'b1, t0);
        check_eq("mid_open", 32'(valid), 32'd1);
        o0 = open_cnt;
        s0 = sync_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_maddr", 32'(maddr), 32'd0);
        check_eq("mid_rst_nosync", 32'(sync_cnt), 32'(s0));
        check_eq("mid_rst_noopen", 32'(open_cnt), 32'(o0));

        // Single write with ready high.
        ready = 1'b1;
        s0 = sync_cnt;
        send_byte(8'h5A, 1'b1, t0);
        check_eq("sw_open_addr", 32'(open_addr), 32'h5A);
        check_eq("sw_open_lat", 32'(open_t - t0), 32'(99 * CLK_P));
        send_byte(8'hC3, 1'b1, t1);
        repeat (5) @(negedge clk);
        check_eq("sw_sync_cnt", 32'(sync_cnt), 32'(s0 + 1));
        check_eq("sw_sync_addr", 32'(sync_addr), 32'h5A);
        check_eq("sw_sync_data", 32'(sync_data), 32'hC3);
        check_eq("sw_sync_valid", 32'(sync_vld), 32'd1);
        check_eq("sw_sync_lat", 32'(sync_t - t1), 32'(99 * CLK_P));
        check_eq("sw_valid_closed", 32'(valid), 32'd0);
        check_eq("sw_err", 32'(err), 32'd0);

        // Ready stall.
        ready = 1'b0;
        s0 = sync_cnt;
        c0 = addr_chg;
        send_byte(8'h12, 1'b1, t0);
        send_byte(8'h34, 1'b1, t1);
        repeat (37) @(negedge clk);
        check_eq("st_valid_held", 32'(valid), 32'd1);
        check_eq("st_mdata_held", 32'(mdata), 32'h34);
        check_eq("st_no_sync", 32'(sync_cnt), 32'(s0));
        ready = 1'b1;
        t_rdy = $time;
        repeat (5) @(negedge clk);
        check_eq("st_sync_cnt", 32'(sync_cnt), 32'(s0 + 1));
        check_eq("st_sync_lat", 32'(sync_t - t_rdy), 32'(CLK_P));
        check_eq("st_sync_addr", 32'(sync_addr), 32'h12);
        check_eq("st_sync_data", 32'(sync_data), 32'h34);
        check_eq("st_addr_stable", 32'(addr_chg), 32'(c0));

        // Framing error, then a good pair.
        o0 = open_cnt;
        send_byte(8'h77, 1'b0, t0);
        repeat (5) @(negedge clk);
        check_eq("fr_err", 32'(err), 32'h1);
        check_eq("fr_no_open", 32'(open_cnt), 32'(o0));
        s0 = sync_cnt;
        send_byte(8'h01, 1'b1, t0);
        send_byte(8'h02, 1'b1, t1);
        repeat (5) @(negedge clk);
        check_eq("fr_pair_cnt", 32'(sync_cnt), 32'(s0 + 1));
        check_eq("fr_pair_addr", 32'(sync_addr), 32'h01);
        check_eq("fr_pair_data", 32'(sync_data), 32'h02);

        // False start; the clear lands on the same cycle as the event, which must win.
        o0 = open_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("fs_err_clr_win", 32'(err), 32'h8);
        check_eq("fs_valid", 32'(valid), 32'd0);
        check_eq("fs_no_open", 32'(open_cnt), 32'(o0));
        pulse_clr();
        repeat (2) @(negedge clk);
        check_eq("fs_err_cleared", 32'(err), 32'd0);

        // Overrun while stalled.
        ready = 1'b0;
        o0 = open_cnt;
        s0 = sync_cnt;
        send_byte(8'hAA, 1'b1, t0);
        send_byte(8'hBB, 1'b1, t0);
        send_byte(8'hCC, 1'b1, t0);
        repeat (5) @(negedge clk);
        check_eq("ov_err", 32'(err), 32'h2);
        check_eq("ov_no_sync", 32'(sync_cnt), 32'(s0));
        @(negedge clk);
        ready = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("ov_sync_cnt", 32'(sync_cnt), 32'(s0 + 1));
        check_eq("ov_sync_addr", 32'(sync_addr), 32'hAA);
        check_eq("ov_sync_data", 32'(sync_data), 32'hBB);
        repeat (200) @(negedge clk);
        check_eq("ov_cc_dropped", 32'(open_cnt), 32'(o0 + 1));
        pulse_clr();
        repeat (2) @(negedge clk);

`ifdef UART_TO_SHK_TIMEOUT_EN
        // Lone address byte times out after 32 bit periods.
        ready = 1'b1;
        send_byte(8'h10, 1'b1, t0);
        repeat (400) @(negedge clk);
        check_eq("to_valid_len", 32'(last_hi_len), 32'd320);
        check_eq("to_err", 32'(err), 32'h4);
        check_eq("to_valid_low", 32'(valid), 32'd0);
        s0 = sync_cnt;
        send_byte(8'h20, 1'b1, t0);
        send_byte(8'h30, 1'b1, t1);
        repeat (5) @(negedge clk);
        check_eq("to_next_cnt", 32'(sync_cnt), 32'(s0 + 1));
        check_eq("to_next_addr", 32'(sync_addr), 32'h20);
        check_eq("to_next_data", 32'(sync_data), 32'h30);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
